// File: rtl/dac_instr_queue_pkg.sv
// rtl/dac_instr_queue_pkg.sv - shared constants for the DAC instruction queue
package dac_instr_queue_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam int         W_CMD_DEF     = 4;
    localparam int         W_ADDR_DEF    = 4;
    localparam int         W_DATA_DEF    = 16;
    localparam logic [3:0] CMD_WRITE_DEF = 4'b0011;

    // Instruction layout, MSB first: {cmd, addr, data}
    function automatic int instr_width(int w_cmd, int w_addr, int w_data);
        return w_cmd + w_addr + w_data;
    endfunction

    // Channel index width; a single channel still needs one bit of storage
    function automatic int idx_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dac_instr_queue_if.sv
// rtl/dac_instr_queue_if.sv - instruction handshake toward the DAC controller
interface dac_instr_queue_if #(
    parameter int W_INSTR = 24
) ();

    logic [W_INSTR-1:0] instr_out;
    logic               instr_valid_out;
    logic               instr_ready_in;

    modport master (
        output instr_out,
        output instr_valid_out,
        input  instr_ready_in
    );

    modport slave (
        input  instr_out,
        input  instr_valid_out,
        output instr_ready_in
    );

endinterface

// File: rtl/dac_instr_queue_rr_arbiter.sv
// rtl/dac_instr_queue_rr_arbiter.sv - combinational round-robin arbiter
module dac_instr_queue_rr_arbiter
    import dac_instr_queue_pkg::*;
#(
    parameter int N     = 8,
    parameter int W_IDX = idx_width(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [W_IDX-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [W_IDX-1:0] idx_o,
    output logic             any_o
);

    // Search starts one past the last grant and wraps, so the last winner goes last
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 1; i <= N; i++) begin
            int j;
            j = int'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = W_IDX'(j);
            end
        end
    end

endmodule

// File: rtl/dac_instr_queue.sv
// rtl/dac_instr_queue.sv - per-channel pending bank, round-robin issue of DAC write instructions
module dac_instr_queue
    import dac_instr_queue_pkg::*;
#(
    parameter int               N_CHAN    = 8,
    parameter int               W_DATA    = W_DATA_DEF,
    parameter int               W_ADDR    = W_ADDR_DEF,
    parameter int               W_CMD     = W_CMD_DEF,
    parameter logic [W_CMD-1:0] CMD_WRITE = W_CMD'(CMD_WRITE_DEF)
) (
    input  logic                       clk_in,
    input  logic                       reset_in,
    input  logic [N_CHAN*W_DATA-1:0]   data_in,
    input  logic [N_CHAN-1:0]          data_valid_in,
    input  logic [N_CHAN-1:0]          chan_en_in,
    dac_instr_queue_if.master          dac_if,
    output logic                       overflow_out
);

    localparam int W_IDX   = idx_width(N_CHAN);
    localparam int W_INSTR = instr_width(W_CMD, W_ADDR, W_DATA);

    logic [N_CHAN-1:0]        in_vld_q, in_vld_d;
    logic [N_CHAN*W_DATA-1:0] in_data_q, in_data_d;
    logic [N_CHAN-1:0]        pend_q, pend_d;
    logic [W_DATA-1:0]        pend_data_q [N_CHAN];
    logic [W_DATA-1:0]        pend_data_d [N_CHAN];
    logic [0:0]               state_q, state_d;
    logic [W_IDX-1:0]         rr_q, rr_d;
    logic [W_INSTR-1:0]       instr_q, instr_d;
    logic                     valid_q, valid_d;
    logic                     ovf_q, ovf_d;

    logic [N_CHAN-1:0]        gnt;
    logic [W_IDX-1:0]         gnt_idx;
    logic                     gnt_any;
    logic                     grant_fire;

    dac_instr_queue_rr_arbiter #(
        .N     (N_CHAN),
        .W_IDX (W_IDX)
    ) u_arb (
        .req_i (pend_q),
        .ptr_i (rr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign grant_fire = (state_q == ST_IDLE) && gnt_any;

    // Input stage: the enable mask is applied as words arrive, so a masked pulse never lands
    always_comb begin
        in_vld_d  = data_valid_in & chan_en_in;
        in_data_d = data_in;
    end

    // Pending bank: a fresh word always wins over a clear from the grant on the same edge
    always_comb begin
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        ovf_d       = ovf_q;
        for (int k = 0; k < N_CHAN; k++) begin
            if (!chan_en_in[k]) begin
                pend_d[k] = 1'b0;
            end else begin
                if (grant_fire && gnt[k]) begin
                    pend_d[k] = 1'b0;
                end
                if (in_vld_q[k]) begin
                    pend_data_d[k] = in_data_q[k*W_DATA +: W_DATA];
                    pend_d[k]      = 1'b1;
                    if (pend_q[k] && !(grant_fire && gnt[k])) begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    state_d = ST_SEND;
                    valid_d = 1'b1;
                    rr_d    = gnt_idx;
                    instr_d = {CMD_WRITE, W_ADDR'(gnt_idx), pend_data_q[gnt_idx]};
                end
            end
            ST_SEND: begin
                if (valid_q && dac_if.instr_ready_in) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            in_vld_q  <= '0;
            in_data_q <= '0;
            pend_q    <= '0;
            for (int k = 0; k < N_CHAN; k++) begin
                pend_data_q[k] <= '0;
            end
            state_q   <= ST_IDLE;
            rr_q      <= W_IDX'(N_CHAN - 1);
            instr_q   <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            in_vld_q    <= in_vld_d;
            in_data_q   <= in_data_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            state_q     <= state_d;
            rr_q        <= rr_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign dac_if.instr_out       = instr_q;
    assign dac_if.instr_valid_out = valid_q;
    assign overflow_out           = ovf_q;

endmodule
